// File: rtl/jt49_div_sched.sv
// Time-multiplexed divider scheduler: one counter/comparator swept over tone A/B/C, noise, envelope.
// Optional JT49_SCHED_ZERO_HALT_EN: a zero period halts its slot instead of acting as period 1.
module jt49_div_sched #(
  parameter int TW = 12,
  parameter int NW = 5,
  parameter int EW = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen16,
  input  logic        cen256,
  input  logic        wr,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  output logic        tone_a,
  output logic        tone_b,
  output logic        tone_c,
  output logic        noise_stb,
  output logic        env_stb,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic {IDLE, SLOT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    slot_q, slot_d;
  logic          envPend_q, envPend_d;
  logic [EW-1:0] period_q [5];
  logic [EW-1:0] count_q  [5];
  logic          toneA_q, toneB_q, toneC_q, noiseStb_q, envStb_q, overrun_q;

  logic [EW-1:0] curCount, curPeriod, wTone, wNoise, wEnv;
  logic [EW:0]   nxt, eff;
  logic          hit, halted;

  assign wTone  = EW'(wdata[TW-1:0]);
  assign wNoise = EW'(wdata[NW-1:0]);
  assign wEnv   = wdata[EW-1:0];

  assign curCount  = count_q[slot_q];
  assign curPeriod = period_q[slot_q];
  assign nxt       = {1'b0, curCount} + 1'b1;
  assign eff       = (curPeriod == '0) ? (EW+1)'(1) : {1'b0, curPeriod};
  assign hit       = (nxt >= eff);

`ifdef JT49_SCHED_ZERO_HALT_EN
  assign halted = (curPeriod == '0);
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      envPend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      envPend_q <= envPend_d;
    end
  end

  // The envelope slot is only visited on sweeps whose request carried cen256.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    envPend_d = envPend_q;
    case (state_q)
      IDLE: begin
        if (cen16) begin
          state_d   = SLOT;
          slot_d    = '0;
          envPend_d = cen256;
        end
      end
      SLOT: begin
        if (slot_q == 3'd3) begin
          if (envPend_q) slot_d = 3'd4;
          else           state_d = IDLE;
        end else if (slot_q == 3'd4) begin
          state_d   = IDLE;
          envPend_d = 1'b0;
        end else begin
          slot_d = slot_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SLOT);
  end

  // Period writes land at the clock edge, so a slot processed in the write cycle still sees the old period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        period_q[i] <= '0;
        count_q[i]  <= '0;
      end
      toneA_q    <= 1'b0;
      toneB_q    <= 1'b0;
      toneC_q    <= 1'b0;
      noiseStb_q <= 1'b0;
      envStb_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      noiseStb_q <= 1'b0;
      envStb_q   <= 1'b0;
      if (cen16 && state_q == SLOT) overrun_q <= 1'b1;
      if (state_q == SLOT) begin
        if (halted) begin
          count_q[slot_q] <= '0;
        end else if (hit) begin
          count_q[slot_q] <= '0;
          case (slot_q)
            3'd0:    toneA_q    <= ~toneA_q;
            3'd1:    toneB_q    <= ~toneB_q;
            3'd2:    toneC_q    <= ~toneC_q;
            3'd3:    noiseStb_q <= 1'b1;
            default: envStb_q   <= 1'b1;
          endcase
        end else begin
          count_q[slot_q] <= nxt[EW-1:0];
        end
      end
      if (wr) begin
        case (waddr)
          3'd0:    period_q[0] <= wTone;
          3'd1:    period_q[1] <= wTone;
          3'd2:    period_q[2] <= wTone;
          3'd3:    period_q[3] <= wNoise;
          3'd4:    period_q[4] <= wEnv;
          default: ;
        endcase
      end
    end
  end

  assign tone_a    = toneA_q;
  assign tone_b    = toneB_q;
  assign tone_c    = toneC_q;
  assign noise_stb = noiseStb_q;
  assign env_stb   = envStb_q;
  assign overrun   = overrun_q;

endmodule
